// File: rtl/alu_share_arbiter_pkg.sv
// rtl/alu_share_arbiter_pkg.sv - ALU opcode and arbiter FSM state types shared by the ALU sharing block
package alu_share_arbiter_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_ops_t;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_EXEC = 2'd1,
        ARB_RESP = 2'd2
    } alu_arb_state_t;

endpackage

// File: rtl/alu_share_arbiter_if.sv
// rtl/alu_share_arbiter_if.sv - per-requester request/response handshake bundle for the shared ALU
interface alu_share_arbiter_if
    import alu_share_arbiter_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int XLEN  = 32
);
    logic     [N_REQ-1:0]           req_valid;
    logic     [N_REQ-1:0]           req_ready;
    alu_ops_t [N_REQ-1:0]           req_op;
    logic     [N_REQ-1:0][XLEN-1:0] req_a;
    logic     [N_REQ-1:0][XLEN-1:0] req_b;
    logic     [N_REQ-1:0]           resp_valid;
    logic     [N_REQ-1:0]           resp_ready;
    logic     [XLEN-1:0]            resp_result;
    logic                           resp_zero;

    modport master (
        output req_valid, req_op, req_a, req_b, resp_ready,
        input  req_ready, resp_valid, resp_result, resp_zero
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, resp_ready,
        output req_ready, resp_valid, resp_result, resp_zero
    );
endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin picker: first set request at or above ptr, wrapping modulo N
module rr_arbiter #(
    parameter int N = 2,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] i_req,
    input  logic [W-1:0] i_ptr,
    output logic [N-1:0] o_grant,
    output logic [W-1:0] o_grant_idx,
    output logic         o_any_grant
);
    logic [W:0] w_k;

    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        o_any_grant = 1'b0;
        w_k         = '0;
        for (int i = 0; i < N; i++) begin
            // Extra bit keeps ptr+i from overflowing before the modulo fold.
            w_k = {1'b0, i_ptr} + (W+1)'(i);
            if (w_k >= (W+1)'(N)) begin
                w_k = w_k - (W+1)'(N);
            end
            if (!o_any_grant && i_req[w_k[W-1:0]]) begin
                o_any_grant           = 1'b1;
                o_grant_idx           = w_k[W-1:0];
                o_grant[w_k[W-1:0]]   = 1'b1;
            end
        end
    end
endmodule

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin sharing of one combinational ALU, one operation in flight (IDLE/EXEC/RESP)
module alu_share_arbiter
    import alu_share_arbiter_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int XLEN  = 32
) (
    input  logic                clk,
    input  logic                rst,
    alu_share_arbiter_if.slave  bus,
    output alu_ops_t            alu_op,
    output logic [XLEN-1:0]     alu_a,
    output logic [XLEN-1:0]     alu_b,
    input  logic [XLEN-1:0]     alu_result,
    input  logic                alu_zero
);
    localparam int PW = $clog2(N_REQ);

    alu_arb_state_t  r_state;
    logic [PW-1:0]   r_rr_ptr;
    logic [PW-1:0]   r_owner;
    alu_ops_t        r_op;
    logic [XLEN-1:0] r_a;
    logic [XLEN-1:0] r_b;
    logic [XLEN-1:0] r_result;
    logic            r_zero;

    logic [N_REQ-1:0] w_grant;
    logic [PW-1:0]    w_grant_idx;
    logic             w_any_grant;
    logic             w_accept;

    rr_arbiter #(
        .N (N_REQ),
        .W (PW)
    ) u_rr_arbiter (
        .i_req       (bus.req_valid),
        .i_ptr       (r_rr_ptr),
        .o_grant     (w_grant),
        .o_grant_idx (w_grant_idx),
        .o_any_grant (w_any_grant)
    );

    assign w_accept        = (r_state == ARB_IDLE) && w_any_grant && !rst;
    assign bus.req_ready   = w_accept ? w_grant : '0;
    assign bus.resp_valid  = (r_state == ARB_RESP) ? (N_REQ'(1) << r_owner) : '0;
    assign bus.resp_result = r_result;
    assign bus.resp_zero   = r_zero;

    // The ALU always sees the issue registers, so its inputs only change on accept.
    assign alu_op = r_op;
    assign alu_a  = r_a;
    assign alu_b  = r_b;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ARB_IDLE;
            r_rr_ptr <= '0;
            r_owner  <= '0;
            r_op     <= ALU_ADD;
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_zero   <= 1'b0;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (w_any_grant) begin
                        r_op     <= bus.req_op[w_grant_idx];
                        r_a      <= bus.req_a[w_grant_idx];
                        r_b      <= bus.req_b[w_grant_idx];
                        r_owner  <= w_grant_idx;
                        r_rr_ptr <= (w_grant_idx == PW'(N_REQ - 1)) ? '0 : w_grant_idx + PW'(1);
                        r_state  <= ARB_EXEC;
                    end
                end
                ARB_EXEC: begin
                    r_result <= alu_result;
                    r_zero   <= alu_zero;
                    r_state  <= ARB_RESP;
                end
                ARB_RESP: begin
                    if (bus.resp_ready[r_owner]) begin
                        r_state <= ARB_IDLE;
                    end
                end
                default: r_state <= ARB_IDLE;
            endcase
        end
    end
endmodule
